// File: rtl/tipi_xfer_ctrl.sv
// TIPI serial register master: turns one-byte commands into r_clk/r_le/r_dout pulse trains.
// Optional repeat-until-change read polling is enabled with `define TIPI_XFER_POLL_EN.
module tipi_xfer_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int POLL_GAP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rt,
  input  logic       cmd_cd,
  input  logic [0:7] cmd_wdata,
  output logic       rsp_valid,
  output logic [0:7] rsp_rdata,
  output logic       busy,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
`ifdef TIPI_XFER_POLL_EN
  ,
  input  logic       poll_mode,
  input  logic [0:7] poll_ref
`endif
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [3:0] LAST_PULSE = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE_LO,
    S_PULSE_HI,
    S_DONE,
    S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] pulse_q, pulse_d, pulse_nxt;
  logic       rt_q, rt_d, cd_q, cd_d;
  logic [0:7] wdata_q, wdata_d, shift_q, shift_d, rdata_q, rdata_d;
  logic       r_clk_q, r_clk_d, r_le_q, r_le_d, r_dout_q, r_dout_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       poll_hit;
`ifdef TIPI_XFER_POLL_EN
  logic       poll_q, poll_d;
  logic [0:7] ref_q, ref_d;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pulse_d     = pulse_q;
    rt_d        = rt_q;
    cd_d        = cd_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    r_le_d      = r_le_q;
    r_dout_d    = r_dout_q;
    rsp_valid_d = 1'b0;
    pulse_nxt   = pulse_q + 4'd1;
    poll_hit    = 1'b0;
`ifdef TIPI_XFER_POLL_EN
    poll_d      = poll_q;
    ref_d       = ref_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_PULSE_LO;
          div_d    = '0;
          pulse_d  = '0;
          rt_d     = cmd_rt;
          cd_d     = cmd_cd;
          wdata_d  = cmd_wdata;
          shift_d  = '0;
          r_le_d   = cmd_rt;
          r_dout_d = ~cmd_rt & cmd_wdata[0];
`ifdef TIPI_XFER_POLL_EN
          poll_d   = cmd_rt & poll_mode;
          ref_d    = poll_ref;
`endif
        end
      end
      S_PULSE_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_PULSE_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_PULSE_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // CPLD registers r_din on the rising edge, so pulse n carries bit n-1.
          if (rt_q && (pulse_q != 4'd0)) shift_d = {shift_q[1:7], r_din};
          if (pulse_q == LAST_PULSE) begin
`ifdef TIPI_XFER_POLL_EN
            poll_hit = poll_q && (shift_d == ref_q);
`endif
            r_le_d   = 1'b0;
            r_dout_d = 1'b0;
            if (poll_hit) begin
              state_d = S_GAP;
            end else begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
              if (rt_q) rdata_d = shift_d;
            end
          end else begin
            pulse_d  = pulse_nxt;
            state_d  = S_PULSE_LO;
            r_le_d   = ~rt_q & (pulse_nxt == LAST_PULSE);
            r_dout_d = ~rt_q & (pulse_nxt != LAST_PULSE) & wdata_q[pulse_nxt[2:0]];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d    = '0;
          pulse_d  = '0;
          state_d  = S_PULSE_LO;
          shift_d  = '0;
          r_le_d   = 1'b1;
          r_dout_d = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // r_clk comes straight from a flop so the CPLD never sees a decode glitch.
    r_clk_d = (state_d == S_PULSE_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      pulse_q     <= '0;
      rt_q        <= 1'b0;
      cd_q        <= 1'b0;
      wdata_q     <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      r_clk_q     <= 1'b0;
      r_le_q      <= 1'b0;
      r_dout_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef TIPI_XFER_POLL_EN
      poll_q      <= 1'b0;
      ref_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pulse_q     <= pulse_d;
      rt_q        <= rt_d;
      cd_q        <= cd_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      r_clk_q     <= r_clk_d;
      r_le_q      <= r_le_d;
      r_dout_q    <= r_dout_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef TIPI_XFER_POLL_EN
      poll_q      <= poll_d;
      ref_q       <= ref_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign r_clk     = r_clk_q;
  assign r_le      = r_le_q;
  assign r_rt      = rt_q;
  assign r_cd      = cd_q;
  assign r_dout    = r_dout_q;

endmodule
